// File: rtl/fifo_wr_arbiter_if.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter_if
//   Bundles the producer-side request lanes and the FIFO write port that the
//   round-robin write arbiter sits between.
//
//   Signals:
//     req        producer -> arbiter   per-requester word-valid
//     req_data   producer -> arbiter   flattened lanes, lane i = [i*DATA_W +: DATA_W]
//     fifo_full  FIFO     -> arbiter   full flag
//     gnt        arbiter  -> producer  registered one-hot grant
//     ack        arbiter  -> producer  combinational word-accepted strobe
//     fifo_wr_en arbiter  -> FIFO      write enable
//     fifo_din   arbiter  -> FIFO      write data
//     grant_id   arbiter  -> observer  index of current/last grantee
//     busy       arbiter  -> observer  high while a grant is held
//
//   Modports:
//     master  the arbiter itself
//     slave   the surrounding producers/FIFO (or a testbench)
// -----------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8
);
   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic                      fifo_full;
   logic [NUM_REQ-1:0]        gnt;
   logic [NUM_REQ-1:0]        ack;
   logic                      fifo_wr_en;
   logic [DATA_W-1:0]         fifo_din;
   logic [ID_W-1:0]           grant_id;
   logic                      busy;

   modport master (
      input  req, req_data, fifo_full,
      output gnt, ack, fifo_wr_en, fifo_din, grant_id, busy
   );

   modport slave (
      output req, req_data, fifo_full,
      input  gnt, ack, fifo_wr_en, fifo_din, grant_id, busy
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//   Round-robin arbiter sharing one FIFO write port between NUM_REQ producers.
//   One requester is granted at a time; the grant is held for at most
//   MAX_BURST accepted words, is stretched (never released) while the FIFO is
//   full, and is dropped early when the grantee withdraws its request. Every
//   grant is followed by exactly one idle cycle before the next arbitration.
//
//   Ports:
//     clk   system clock, all state on the rising edge
//     rst   asynchronous active-high reset
//     bus   fifo_wr_arbiter_if.master: req/req_data/fifo_full in,
//           gnt/ack/fifo_wr_en/fifo_din/grant_id/busy out
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                clk,
   input  logic                rst,
   fifo_wr_arbiter_if.master   bus
);
   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [ID_W-1:0]    grant_id_q, grant_id_d;
   logic [3:0]         burst_cnt_q, burst_cnt_d;

   logic [NUM_REQ-1:0] ack;
   logic               wr_en;
   logic [DATA_W-1:0]  din;

   logic               win_found;
   logic [ID_W-1:0]    win_id;
   logic [ID_W-1:0]    scan_idx;
   logic               last_word;
   logic               release_gnt;

   // Accept path: purely combinational so a word is written on the same edge
   // it is acknowledged. The full flag gates every ack, which is what keeps
   // fifo_wr_en low whenever the FIFO is full.
   always_comb begin
      ack   = gnt_q & bus.req & {NUM_REQ{~bus.fifo_full}};
      wr_en = |ack;
      din   = '0;
      // ack is at most one-hot, so an AND-OR mux selects the granted lane
      // and yields zero when nothing is written.
      for (int i = 0; i < NUM_REQ; i++) begin
         if (ack[i]) begin
            din = din | bus.req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Round-robin search starting just after the last grantee. Scanning from
   // the farthest offset down to the nearest lets the nearest hit win without
   // a priority chain; the offset sum wraps naturally since NUM_REQ is 2**ID_W.
   always_comb begin
      win_found = 1'b0;
      win_id    = grant_id_q;
      scan_idx  = grant_id_q;
      for (int k = NUM_REQ; k >= 1; k--) begin
         scan_idx = grant_id_q + ID_W'(k);
         if (bus.req[scan_idx]) begin
            win_found = 1'b1;
            win_id    = scan_idx;
         end
      end
   end

   // The MAX_BURST-th word releases the grant; a withdrawn request releases it
   // regardless of the count. Both together still give a single release.
   assign last_word   = (burst_cnt_q == 4'(MAX_BURST - 1));
   assign release_gnt = ~bus.req[grant_id_q] | (wr_en & last_word);

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      grant_id_d  = grant_id_q;
      burst_cnt_d = burst_cnt_q;
      case (state_q)
         IDLE: begin
            if (win_found) begin
               state_d        = GRANT;
               gnt_d          = '0;
               gnt_d[win_id]  = 1'b1;
               grant_id_d     = win_id;
               burst_cnt_d    = '0;
            end
         end
         GRANT: begin
            if (release_gnt) begin
               state_d     = IDLE;
               gnt_d       = '0;
               burst_cnt_d = '0;
            end else if (wr_en) begin
               burst_cnt_d = burst_cnt_q + 4'd1;
            end
         end
         default: begin
            state_d     = IDLE;
            gnt_d       = '0;
            burst_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         gnt_q       <= '0;
         // Pointing at the last requester makes requester 0 the first
         // candidate after reset.
         grant_id_q  <= ID_W'(NUM_REQ - 1);
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         grant_id_q  <= grant_id_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

   assign bus.gnt        = gnt_q;
   assign bus.ack        = ack;
   assign bus.fifo_wr_en = wr_en;
   assign bus.fifo_din   = din;
   assign bus.grant_id   = grant_id_q;
   assign bus.busy       = (state_q == GRANT);

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares a single 8-bit FIFO write port between NUM_REQ producers.
- Grants one requester at a time and holds the grant for a bounded burst.
- Stalls the burst on FIFO full.
- Drives the FIFO's write enable and data input directly. Sits between producer blocks and the FIFO.

Parameters:
- NUM_REQ, 4, number of requesters (power of 2, 2..8).
- DATA_W, 8, data width per requester and of the FIFO write port.
- MAX_BURST, 4, maximum words accepted per grant before forced release (1..15).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous active-high reset.
- req  input  NUM_REQ  per-requester write request; bit i held high while requester i has a word on its data lane.
- req_data  input  NUM_REQ*DATA_W  flattened data lanes; lane i = bits [i*DATA_W +: DATA_W].
- fifo_full  input  1  full flag from the FIFO.
- gnt  output  NUM_REQ  registered one-hot grant (all-zero when idle).
- ack  output  NUM_REQ  combinational per-requester word-accepted strobe.
- fifo_wr_en  output  1  combinational FIFO write enable.
- fifo_din  output  DATA_W  combinational FIFO write data.
- grant_id  output  log2(NUM_REQ)  registered index of the current or last grantee.
- busy  output  1  registered; high in GRANT state.

Behaviour:
- Reset (async, immediate): state=IDLE, gnt=0, busy=0, grant_id=NUM_REQ-1, burst_cnt=0. ack, fifo_wr_en and fifo_din are 0 because gnt=0. Requester 0 has first priority after reset.
- Accept rule: ack[i] = gnt[i] & req[i] & !fifo_full.
  - fifo_wr_en = OR of ack.
  - fifo_din = lane of the granted requester when fifo_wr_en=1, else 0.
  - Zero latency: the word is written on the same edge it is acked.
- State IDLE:
  - If any req bit is set, pick the first set bit searching grant_id+1, grant_id+2, ... modulo NUM_REQ.
  - Next edge: gnt=one-hot(winner), grant_id=winner, busy=1, burst_cnt=0, state=GRANT.
  - If no req is set, stay in IDLE; grant_id holds.
- State GRANT:
  - Each acked word increments burst_cnt (4-bit, never wraps; bounded by MAX_BURST).
  - Release to IDLE (next edge gnt=0, busy=0, burst_cnt=0) when either:
    - req[grant_id]=0 in the current cycle; or
    - an ack occurs while burst_cnt==MAX_BURST-1 (the MAX_BURST-th word).
  - fifo_full=1 stalls: no ack, burst_cnt holds, grant holds. A granted requester is never released because of full alone.
- Bubble: exactly one IDLE cycle between consecutive grants, so two back-to-back grants are separated by one cycle of gnt=0. Worst-case wait for any persistently requesting producer is (NUM_REQ-1)*(MAX_BURST+1) accept-cycles, excluding full stalls.
- Requests arriving while in GRANT are not seen until the next IDLE cycle. Changes of other req bits do not affect the current grant.
- Simultaneous release conditions (req drop on the same cycle as the last burst word) give a single release. A word is only written if req was high in that cycle.
- The FIFO must never see fifo_wr_en=1 while fifo_full=1 (invariant).
- Mid-burst reset: gnt and fifo_wr_en drop immediately (asynchronously). No partial state survives. Arbitration restarts from requester 0.

Test Plan:
- Single requester: req=4'b0100 held, lane2 = 0xA0,0xA1,..., fifo_full=0 -> gnt=0100 one cycle after req. Exactly 4 writes 0xA0..0xA3, then one idle cycle, then re-grant to 2, continuing with 0xA4.
- All four requesting continuously, full=0 -> grant order 0,1,2,3,0. Each grant writes 4 words with one gap cycle. grant_id sequence 0,1,2,3,0.
- Requester 1 granted, fifo_full high for 3 cycles after its 2nd word -> no ack or fifo_wr_en during the stall. burst_cnt holds at 2. Words 3 and 4 are written after full drops, then release.
- Requester 3 drops req after 1 word, with req0 also pending -> release after 1 word, IDLE one cycle, then grant to requester 0 (wrap from 3).
- Requester 0 drops req on the same cycle its 4th word is acked -> 4 words written, one release, no extra write.
- Assert rst mid-burst (requester 2, 2 words done) -> gnt=0 and fifo_wr_en=0 with no clock edge. After release with req=4'b0101, requester 0 is granted first.
